div_unit: RTL

//  Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU) beside the register file.

---
 rtl/div_pkg.sv | 28 ++
 rtl/div_step.sv | 25 ++
 rtl/div_unit.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative RV32M divide unit: funct3 encodings
// of the four divide/remainder instructions and the FSM state encoding.
package div_pkg;

  localparam logic [2:0] FUNCT3_DIV  = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU = 3'b101;
  localparam logic [2:0] FUNCT3_REM  = 3'b110;
  localparam logic [2:0] FUNCT3_REMU = 3'b111;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  // Signed variants take operand signs into account; unsigned use raw bits.
  function automatic logic funct3_is_signed(input logic [2:0] f);
    return (f == FUNCT3_DIV) || (f == FUNCT3_REM);
  endfunction

  // Remainder variants write back the remainder instead of the quotient.
  function automatic logic funct3_is_rem(input logic [2:0] f);
    return (f == FUNCT3_REM) || (f == FUNCT3_REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 division step: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep the difference when it
// does not underflow. The quotient bit is set whenever the subtract succeeds.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem,
  input  logic            msb,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_next,
  output logic            q_bit
);

  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] diff;

  // Trial subtract on an XLEN+2 wide copy so the top bit is a clean borrow.
  always_comb begin
    shifted  = {rem, msb};
    diff     = shifted - {2'b00, divisor};
    q_bit    = ~diff[XLEN+1];
    rem_next = q_bit ? diff[XLEN:0] : shifted[XLEN:0];
  end

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M divide/remainder unit. Accepts a divide from the decoder,
// holds the core with stall while computing one quotient bit per cycle, and
// pulses a single-cycle register-file write with the quotient or remainder.
// Divide-by-zero and signed overflow bypass the iteration and finish at once.
//
// Handshake: start is a level request held by the core while stall=1. An
// operation is accepted on the clock edge where state is IDLE and start is
// high; the result is delivered in the single DONE cycle (wb_en=1, stall=0),
// which is also the edge where the core advances past the instruction.
module div_unit
  import div_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [2:0]            funct3,
  input  logic [XLEN-1:0]       op_a,
  input  logic [XLEN-1:0]       op_b,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  stall,
  output logic                  busy,
  output logic                  wb_en,
  output logic [ADDR_WIDTH-1:0] wb_addr,
  output logic [XLEN-1:0]       wb_data,
  output logic [STATE_W-1:0]    dbg_state
);

  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t            state;
  logic [CNT_W-1:0]      count;
  logic [XLEN-1:0]       dvd_q;     // dividend shifting out, quotient shifting in
  logic [XLEN-1:0]       dvs_q;     // divisor magnitude
  logic [XLEN:0]         rem_q;     // partial remainder, one spare bit
  logic                  q_neg;
  logic                  r_neg;
  logic                  is_rem;
  logic [ADDR_WIDTH-1:0] rd_q;

  // Decode of the incoming instruction, only meaningful in IDLE.
  logic            in_signed;
  logic            in_rem;
  logic            sign_a;
  logic            sign_b;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic            div_zero;
  logic            overflow;
  logic [XLEN-1:0] special_res;

  // Iteration datapath.
  logic [XLEN:0]   step_rem;
  logic            step_q;
  logic [XLEN-1:0] quot_final;
  logic [XLEN-1:0] rem_final;
  logic [XLEN-1:0] fixed_res;

  // Stall is combinational so the PC is released in the DONE cycle itself.
  assign stall     = start & (state != ST_DONE);
  assign busy      = (state == ST_CALC);
  assign dbg_state = state;

  // Operand decode: signs, magnitudes and the two short-circuit cases.
  always_comb begin
    in_signed   = funct3_is_signed(funct3);
    in_rem      = funct3_is_rem(funct3);
    sign_a      = in_signed & op_a[XLEN-1];
    sign_b      = in_signed & op_b[XLEN-1];
    abs_a       = sign_a ? (~op_a + 1'b1) : op_a;
    abs_b       = sign_b ? (~op_b + 1'b1) : op_b;
    div_zero    = (op_b == '0);
    overflow    = in_signed & (op_a == MIN_NEG) & (op_b == '1);
    special_res = '0;
    if (div_zero) begin
      special_res = in_rem ? op_a : '1;
    end else if (overflow) begin
      special_res = in_rem ? '0 : op_a;
    end
  end

  div_step #(
    .XLEN (XLEN)
  ) u_step (
    .rem      (rem_q),
    .msb      (dvd_q[XLEN-1]),
    .divisor  (dvs_q),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  // Final quotient/remainder of the last step with the sign fix-up applied.
  always_comb begin
    quot_final = {dvd_q[XLEN-2:0], step_q};
    rem_final  = step_rem[XLEN-1:0];
    fixed_res  = '0;
    if (is_rem) begin
      fixed_res = r_neg ? (~rem_final + 1'b1) : rem_final;
    end else begin
      fixed_res = q_neg ? (~quot_final + 1'b1) : quot_final;
    end
  end

  // Control FSM, iteration registers and registered write-back outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      count   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      is_rem  <= 1'b0;
      rd_q    <= '0;
      wb_en   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else begin
      wb_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            rd_q   <= rd_addr;
            is_rem <= in_rem;
            q_neg  <= sign_a ^ sign_b;
            r_neg  <= sign_a;
            if (div_zero || overflow) begin
              wb_data <= special_res;
              wb_addr <= rd_addr;
              wb_en   <= 1'b1;
              state   <= ST_DONE;
            end else begin
              dvd_q <= abs_a;
              dvs_q <= abs_b;
              rem_q <= '0;
              count <= CNT_W'(XLEN);
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          dvd_q <= {dvd_q[XLEN-2:0], step_q};
          rem_q <= step_rem;
          count <= count - 1'b1;
          if (count == CNT_W'(1)) begin
            wb_data <= fixed_res;
            wb_addr <= rd_q;
            wb_en   <= 1'b1;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
